// File: rtl/sa4way_cache_if.sv
// sa4way_cache_if: CPU load/store port and line-wide memory port of the 4-way cache
//   slave  (cache): takes CPU requests and memory responses; drives ready/response and memory requests
//   master (bench/CPU+memory): the opposite directions
interface sa4way_cache_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LINE_W = 128
);
  logic              i_req_valid;
  logic              i_req_rw;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_data_w;
  logic              o_ready;
  logic              o_resp_valid;
  logic [DATA_W-1:0] o_data;
  logic              o_mem_req;
  logic              o_mem_rw;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [LINE_W-1:0] o_mem_line;
  logic              i_memory_response;
  logic [LINE_W-1:0] i_memory_line;
  modport slave (
    input  i_req_valid, i_req_rw, i_addr, i_data_w, i_memory_response, i_memory_line,
    output o_ready, o_resp_valid, o_data, o_mem_req, o_mem_rw, o_mem_addr, o_mem_line
  );
  modport master (
    output i_req_valid, i_req_rw, i_addr, i_data_w, i_memory_response, i_memory_line,
    input  o_ready, o_resp_valid, o_data, o_mem_req, o_mem_rw, o_mem_addr, o_mem_line
  );
endinterface

// File: rtl/sa4way_cache.sv
// sa4way_cache: 4-way set-associative write-back write-allocate data cache with tree PLRU
//   clk, rst : clock and synchronous active-high reset
//   bus      : CPU request/response and line-wide memory request/response (sa4way_cache_if.slave)
module sa4way_cache #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int SETS           = 16
) (
  input logic           clk,
  input logic           rst,
  sa4way_cache_if.slave bus
);
  localparam int WAYS   = 4;
  localparam int LINE_W = DATA_W * WORDS_PER_LINE;
  localparam int BYTE_W = $clog2(DATA_W / 8);
  localparam int OFF_W  = $clog2(WORDS_PER_LINE * DATA_W / 8);
  localparam int WORD_W = OFF_W - BYTE_W;
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int LA_W   = ADDR_W - OFF_W;

  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, FILL} state_t;

  state_t              r_state, w_state_nx;
  logic                r_rw;
  logic [LA_W-1:0]     r_line;
  logic [WORD_W-1:0]   r_word;
  logic [DATA_W-1:0]   r_wdata;
  logic [1:0]          r_victim;
  logic [SETS-1:0]     r_valid [WAYS];
  logic [SETS-1:0]     r_dirty [WAYS];
  logic [2:0]          r_plru  [SETS];
  logic [TAG_W-1:0]    r_tag   [WAYS][SETS];
  logic [LINE_W-1:0]   r_data  [WAYS][SETS];

  logic [IDX_W-1:0]    w_idx;
  logic [TAG_W-1:0]    w_tag;
  logic [WAYS-1:0]     w_hit_vec;
  logic [WAYS-1:0]     w_inv_vec;
  logic                w_hit;
  logic [1:0]          w_hit_way;
  logic [1:0]          w_inv_way;
  logic [1:0]          w_plru_way;
  logic [1:0]          w_victim;
  logic                w_vic_dirty;
  logic [2:0]          w_plru_cur;
  logic [2:0]          w_plru_nx;
  logic [LINE_W-1:0]   w_hit_line;
  logic                w_rsp;
  logic                w_unused;

  assign w_unused = ^bus.i_addr[BYTE_W-1:0];
  assign w_idx    = r_line[IDX_W-1:0];
  assign w_tag    = r_line[LA_W-1:IDX_W];
  assign w_rsp    = bus.i_memory_response;

  always_comb begin
    w_hit_vec = '0;
    w_inv_vec = '0;
    for (int w = 0; w < WAYS; w++) begin
      w_hit_vec[w] = r_valid[w][w_idx] && (r_tag[w][w_idx] == w_tag);
      w_inv_vec[w] = !r_valid[w][w_idx];
    end
  end

  assign w_hit      = |w_hit_vec;
  assign w_hit_way  = w_hit_vec[0] ? 2'd0 : w_hit_vec[1] ? 2'd1 : w_hit_vec[2] ? 2'd2 : 2'd3;
  assign w_inv_way  = w_inv_vec[0] ? 2'd0 : w_inv_vec[1] ? 2'd1 : w_inv_vec[2] ? 2'd2 : 2'd3;
  assign w_plru_cur = r_plru[w_idx];
  // PLRU bits are {b2,b1,b0}: b0 picks the way pair, b1/b2 pick within the pair
  assign w_plru_way = w_plru_cur[0] ? {1'b1, w_plru_cur[2]} : {1'b0, w_plru_cur[1]};
  assign w_victim   = (|w_inv_vec) ? w_inv_way : w_plru_way;
  assign w_vic_dirty = r_dirty[w_victim][w_idx];
  // point the tree away from the way just used
  assign w_plru_nx  = w_hit_way[1] ? {~w_hit_way[0], w_plru_cur[1], 1'b0}
                                   : {w_plru_cur[2], ~w_hit_way[0], 1'b1};
  assign w_hit_line = r_data[w_hit_way][w_idx];

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:      if (bus.i_req_valid) w_state_nx = COMPARE;
      COMPARE:   w_state_nx = w_hit ? IDLE : (w_vic_dirty ? WRITEBACK : FILL);
      WRITEBACK: if (w_rsp) w_state_nx = FILL;
      FILL:      if (w_rsp) w_state_nx = COMPARE;
      default:   w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_rw     <= 1'b0;
      r_line   <= '0;
      r_word   <= '0;
      r_wdata  <= '0;
      r_victim <= '0;
      for (int w = 0; w < WAYS; w++) begin
        r_valid[w] <= '0;
        r_dirty[w] <= '0;
      end
      for (int s = 0; s < SETS; s++) r_plru[s] <= '0;
    end else begin
      r_state <= w_state_nx;
      if (r_state == IDLE && bus.i_req_valid) begin
        r_rw    <= bus.i_req_rw;
        r_line  <= bus.i_addr[ADDR_W-1:OFF_W];
        r_word  <= bus.i_addr[OFF_W-1:BYTE_W];
        r_wdata <= bus.i_data_w;
      end
      if (r_state == COMPARE && w_hit) begin
        r_plru[w_idx] <= w_plru_nx;
        if (r_rw) r_dirty[w_hit_way][w_idx] <= 1'b1;
      end
      if (r_state == COMPARE && !w_hit) r_victim <= w_victim;
      if (r_state == WRITEBACK && w_rsp) r_dirty[r_victim][w_idx] <= 1'b0;
      if (r_state == FILL && w_rsp) begin
        r_valid[r_victim][w_idx] <= 1'b1;
        r_dirty[r_victim][w_idx] <= 1'b0;
      end
    end
  end

  // tag and data arrays carry no reset; a cleared valid bit makes their contents irrelevant
  always_ff @(posedge clk) begin
    if (!rst && r_state == COMPARE && w_hit && r_rw)
      r_data[w_hit_way][w_idx][DATA_W*r_word +: DATA_W] <= r_wdata;
    if (!rst && r_state == FILL && w_rsp) begin
      r_data[r_victim][w_idx] <= bus.i_memory_line;
      r_tag[r_victim][w_idx]  <= w_tag;
    end
  end

  assign bus.o_ready      = r_state == IDLE;
  assign bus.o_resp_valid = r_state == COMPARE && w_hit;
  assign bus.o_data       = (r_state == COMPARE && w_hit && !r_rw) ? w_hit_line[DATA_W*r_word +: DATA_W] : '0;
  assign bus.o_mem_req    = r_state == WRITEBACK || r_state == FILL;
  assign bus.o_mem_rw     = r_state == WRITEBACK;
  assign bus.o_mem_addr   = r_state == WRITEBACK ? {r_tag[r_victim][w_idx], w_idx, {OFF_W{1'b0}}}
                          : r_state == FILL      ? {r_line, {OFF_W{1'b0}}} : '0;
  assign bus.o_mem_line   = r_state == WRITEBACK ? r_data[r_victim][w_idx] : '0;
endmodule

// File: tb/tb_sa4way_cache.sv
// tb_sa4way_cache: scoreboard bench for sa4way_cache with a small auto-responding memory
module tb_sa4way_cache;
  typedef struct packed {logic chk; logic [31:0] d;} resp_t;
  typedef struct packed {logic rw; logic [31:0] a; logic [127:0] line;} mem_t;

  localparam logic [127:0] L0   = 128'h44443333_22221111_AAAABBBB_CCCCDDDD;
  localparam logic [127:0] L_WB = 128'h44443333_22221111_AAAABBBB_DEADBEEF;

  logic clk = 0;
  logic rst = 1;
  int   n_tot = 0;
  int   n_bad = 0;
  int   n_resp = 0;
  logic auto_mem = 1;
  logic late = 0;
  resp_t q_resp[$];
  mem_t  q_mem[$];

  sa4way_cache_if bus ();
  sa4way_cache dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [127:0] fill_line(input logic [31:0] a);
    return a == 32'h100 ? L0 : {a + 32'd12, a + 32'd8, a + 32'd4, a};
  endfunction

  task automatic chk(input string n, input logic [127:0] g, input logic [127:0] e);
    n_tot++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL %0s got=%h exp=%h", n, g, e);
    end
  endtask

  task automatic mexp(input logic rw, input logic [31:0] a, input logic [127:0] line);
    q_mem.push_back(mem_t'{rw, a, line});
  endtask

  task automatic issue(input logic rw, input logic [31:0] a, input logic [31:0] d);
    int t = 0;
    while (!bus.o_ready && t < 100) begin @(negedge clk); t++; end
    if (!bus.o_ready) chk("ready_timeout", 0, 1);
    bus.i_req_valid = 1;
    bus.i_req_rw    = rw;
    bus.i_addr      = a;
    bus.i_data_w    = d;
    @(posedge clk);
    #1 bus.i_req_valid = 0;
  endtask

  task automatic cpu(input logic rw, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] e, input int exp_lat);
    int base;
    int lat = 0;
    q_resp.push_back(resp_t'{!rw, e});
    base = n_resp;
    issue(rw, a, d);
    while (n_resp == base && lat < 80) begin @(negedge clk); #1; lat++; end
    if (n_resp == base) chk("resp_timeout", 0, 1);
    else if (exp_lat > 0) chk("hit_latency", lat, exp_lat);
  endtask

  initial begin
    int n = 0;
    bus.i_memory_response = 0;
    bus.i_memory_line = '0;
    forever begin
      @(negedge clk);
      bus.i_memory_response = 0;
      if (late) begin
        bus.i_memory_response = 1;
        bus.i_memory_line = fill_line(32'h110);
        late = 0;
      end else if (auto_mem && bus.o_mem_req) begin
        n++;
        if (n == 3) begin
          bus.i_memory_response = 1;
          bus.i_memory_line = bus.o_mem_rw ? '0 : fill_line(bus.o_mem_addr);
          n = 0;
        end
      end else n = 0;
    end
  end

  initial begin
    logic prev = 0;
    logic prev_rw = 0;
    resp_t r;
    mem_t m;
    forever begin
      @(negedge clk);
      if (rst) prev = 0;
      else begin
        if (bus.o_resp_valid) begin
          n_resp++;
          if (q_resp.size() == 0) chk("unexpected_resp", 1, 0);
          else begin
            r = q_resp.pop_front();
            if (r.chk) chk("rdata", bus.o_data, r.d);
          end
        end
        if (bus.o_mem_req && (!prev || bus.o_mem_rw != prev_rw)) begin
          if (q_mem.size() == 0) chk("unexpected_mem_req", 1, 0);
          else begin
            m = q_mem.pop_front();
            chk("mem_rw", bus.o_mem_rw, m.rw);
            chk("mem_addr", bus.o_mem_addr, m.a);
            if (m.rw) chk("mem_line", bus.o_mem_line, m.line);
          end
        end
        prev = bus.o_mem_req;
        prev_rw = bus.o_mem_rw;
      end
    end
  end

  initial begin
    int t;
    bus.i_req_valid = 0;
    bus.i_req_rw = 0;
    bus.i_addr = '0;
    bus.i_data_w = '0;
    repeat (3) @(negedge clk);
    rst = 0;
    chk("rst_ready", bus.o_ready, 1);
    chk("rst_resp_valid", bus.o_resp_valid, 0);
    chk("rst_mem_req", bus.o_mem_req, 0);
    chk("rst_data", bus.o_data, 0);
    chk("rst_mem_addr", bus.o_mem_addr, 0);
    mexp(0, 32'h100, '0); cpu(0, 32'h104, 0, 32'hAAAABBBB, 0);
    cpu(0, 32'h108, 0, 32'h22221111, 1);
    cpu(1, 32'h100, 32'hDEADBEEF, 0, 1);
    cpu(0, 32'h100, 0, 32'hDEADBEEF, 1);
    cpu(0, 32'h10C, 0, 32'h44443333, 1);
    mexp(0, 32'h200, '0); cpu(0, 32'h208, 0, 32'h208, 0);
    mexp(0, 32'h300, '0); cpu(0, 32'h300, 0, 32'h300, 0);
    mexp(0, 32'h400, '0); cpu(0, 32'h40C, 0, 32'h40C, 0);
    mexp(1, 32'h100, L_WB); mexp(0, 32'h500, '0); cpu(0, 32'h504, 0, 32'h504, 0);
    cpu(0, 32'h500, 0, 32'h500, 1);
    mexp(0, 32'h600, '0); cpu(0, 32'h600, 0, 32'h600, 0);
    cpu(0, 32'h404, 0, 32'h404, 1);
    mexp(0, 32'h300, '0); cpu(0, 32'h308, 0, 32'h308, 0);
    mexp(0, 32'h700, '0); cpu(1, 32'h708, 32'h77, 0, 0);
    cpu(0, 32'h708, 0, 32'h77, 1);
    cpu(0, 32'h704, 0, 32'h704, 1);
    auto_mem = 0;
    mexp(0, 32'h110, '0);
    issue(0, 32'h114, 0);
    t = 0;
    while (!bus.o_mem_req && t < 20) begin @(negedge clk); t++; end
    chk("fill_started", bus.o_mem_req, 1);
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("midfill_rst_mem_req", bus.o_mem_req, 0);
    chk("midfill_rst_ready", bus.o_ready, 1);
    late = 1;
    repeat (3) @(negedge clk);
    chk("late_rsp_mem_req", bus.o_mem_req, 0);
    chk("late_rsp_ready", bus.o_ready, 1);
    auto_mem = 1;
    mexp(0, 32'h100, '0); cpu(0, 32'h104, 0, 32'hAAAABBBB, 0);
    mexp(0, 32'h110, '0); cpu(0, 32'h114, 0, 32'h114, 0);
    repeat (5) @(negedge clk);
    chk("resp_queue_empty", q_resp.size(), 0);
    chk("mem_queue_empty", q_mem.size(), 0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule

// File: doc/sa4way_cache.md
Name: sa4way_cache

Overview:
- 4-way set-associative, write-back, write-allocate data cache.
- Sits between a single-issue CPU load/store port and a line-wide memory port.
- One outstanding CPU request at a time.
- Tree pseudo-LRU replacement; misses fill a full line from memory, writing back a dirty victim first.

Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, CPU word width
- WORDS_PER_LINE, 4, words per line (line = 128 bits, offset = addr[3:0])
- SETS, 16, sets per way (index = addr[7:4], tag = addr[31:8])

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset; synchronous to clk, active-high
- i_req_valid  in  1  CPU request present
- i_req_rw  in  1  1 = write, 0 = read
- i_addr  in  ADDR_W  byte address; addr[3:2] selects word, addr[1:0] ignored
- i_data_w  in  DATA_W  write data
- o_ready  out  1  cache idle, can accept a request
- o_resp_valid  out  1  one-cycle pulse, request completed
- o_data  out  DATA_W  read data, valid with o_resp_valid
- o_mem_req  out  1  memory request, held until response
- o_mem_rw  out  1  1 = line write-back, 0 = line fill
- o_mem_addr  out  ADDR_W  line-aligned address, bits[3:0] = 0
- o_mem_line  out  128  write-back line data
- i_memory_response  in  1  one-cycle pulse, memory transaction done
- i_memory_line  in  128  fill data, valid when i_memory_response = 1 and o_mem_rw = 0

Behaviour:
- Reset (rst = 1 at a clk edge):
  - Clears all valid bits, dirty bits and PLRU bits.
  - FSM goes to IDLE.
  - o_resp_valid, o_mem_req, o_mem_rw, o_data, o_mem_addr and o_mem_line all go to 0.
  - Data and tag arrays are not cleared.
  - Reset mid-miss abandons the transaction; a late i_memory_response is ignored.
- FSM states: IDLE, COMPARE, WRITEBACK, FILL.
- IDLE:
  - o_ready = 1.
  - When i_req_valid = 1, latch rw/addr/data and go to COMPARE.
- COMPARE:
  - o_ready = 0.
  - Tag compare across all 4 ways of the set (valid && tag match).
- Hit:
  - Read: o_data = selected word.
  - Write: update the word and set dirty.
  - Pulse o_resp_valid this cycle, update PLRU, return to IDLE.
  - Hit latency = 1 cycle after acceptance.
- Miss, victim selection:
  - Victim = lowest-index invalid way.
  - If none, the PLRU victim is used.
  - Victim dirty -> WRITEBACK; otherwise -> FILL.
- WRITEBACK:
  - o_mem_req = 1, o_mem_rw = 1.
  - o_mem_addr = {victim tag, index, 4'b0}; o_mem_line = victim line.
  - On i_memory_response: clear dirty, go to FILL.
- FILL:
  - o_mem_req = 1, o_mem_rw = 0, o_mem_addr = request line address.
  - On i_memory_response: write i_memory_line into the victim, set tag, valid = 1, dirty = 0, return to COMPARE.
  - The request now hits, completing as above.
- Memory outputs are stable while o_mem_req = 1.
- i_memory_response is ignored outside WRITEBACK/FILL.
- PLRU (3 bits per set, b0/b1/b2):
  - Victim: b0 = 0 -> (b1 = 0 ? way0 : way1); b0 = 1 -> (b2 = 0 ? way2 : way3).
  - Update on every hit (including the post-fill hit):
    - way0: b0 = 1, b1 = 1
    - way1: b0 = 1, b1 = 0
    - way2: b0 = 0, b2 = 1
    - way3: b0 = 0, b2 = 0
- Line data word w occupies bits [32w+31:32w].
- i_req_valid while o_ready = 0 is ignored; the CPU must hold or reissue the request.

Test Plan:
- Reset, then idle: o_ready = 1, o_resp_valid = 0, o_mem_req = 0; a read of 0x100 misses (all valid = 0).
- Cold read miss 0x0000_0104: o_mem_req = 1, o_mem_rw = 0, o_mem_addr = 0x100. Respond with line 0x44443333_22221111_AAAABBBB_CCCCDDDD -> one cycle later o_resp_valid = 1, o_data = 0xAAAABBBB.
- Read hit 0x108 after that fill: o_resp_valid one cycle after acceptance, o_data = 0x22221111, no memory request.
- Write hit 0x100 with 0xDEADBEEF, then fill set 0 tags 1,2,3,4 (0x100, 0x200, 0x300, 0x400, 0x500):
  - The 5th miss evicts way0 (tag 1) with o_mem_rw = 1, o_mem_addr = 0x100, o_mem_line[31:0] = 0xDEADBEEF.
  - Then a fill from 0x500.
- PLRU order: after fills of ways 0–3 in set 0 and a hit on way0, the next miss evicts way2; a clean victim goes straight to fill with no write-back.
- Reset asserted during FILL: FSM returns to IDLE; a late i_memory_response causes no state change; a re-read of 0x104 misses again.
